// File: rtl/pair_checker_pkg.sv
// Shared types, default widths and label extraction helper for the pair checker.
package pair_checker_pkg;

   // Turn-controller states
   typedef enum logic [2:0] {
      PICK1,
      PICK2,
      COMPARE,
      SHOW,
      HIDE,
      DONE
   } state_e;

   // Default board geometry
   localparam int DEF_N_TILES     = 16;
   localparam int DEF_IDX_W       = 4;
   localparam int DEF_LABEL_W     = 4;
   localparam int DEF_SHOW_CYCLES = 50000000;
   localparam int DEF_SCORE_W     = 4;

   // Upper bounds accepted by label_at; callers size-cast their flat vector to FLAT_MAX
   localparam int FLAT_MAX  = 1024;
   localparam int LABEL_MAX = 8;

   // Returns label idx (lw bits wide, zero-extended) from a flat label vector
   function automatic logic [LABEL_MAX-1:0] label_at(
      input logic [FLAT_MAX-1:0] flat,
      input int unsigned         idx,
      input int unsigned         lw
   );
      logic [FLAT_MAX-1:0]  shifted;
      logic [LABEL_MAX-1:0] mask;
      shifted = flat >> (idx * lw);
      mask    = (LABEL_MAX'(1) << lw) - LABEL_MAX'(1);
      return LABEL_MAX'(shifted) & mask;
   endfunction

endpackage

// File: rtl/pair_checker_if.sv
// Board-side bus of the pair checker: tile picks and labels in, tile control and score out.
interface pair_checker_if
   import pair_checker_pkg::*;
#(
   parameter int N_TILES = DEF_N_TILES,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int LABEL_W = DEF_LABEL_W,
   parameter int SCORE_W = DEF_SCORE_W
);
   logic                       select;
   logic [IDX_W-1:0]           cursor;
   logic [N_TILES*LABEL_W-1:0] labels;
   logic [N_TILES-1:0]         hide;
   logic [N_TILES-1:0]         matched;
   logic                       player;
   logic [SCORE_W-1:0]         score0;
   logic [SCORE_W-1:0]         score1;
   logic                       busy;
   logic                       game_over;

   // Board / input side: drives picks and labels, observes game outputs
   modport master (
      output select, cursor, labels,
      input  hide, matched, player, score0, score1, busy, game_over
   );

   // Turn controller side
   modport slave (
      input  select, cursor, labels,
      output hide, matched, player, score0, score1, busy, game_over
   );
endinterface

// File: rtl/pair_checker_show_timer.sv
// Loadable down-counter timing how long a mismatched pair stays revealed.
module show_timer
   import pair_checker_pkg::*;
#(
   parameter int CYCLES = DEF_SHOW_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done
);
   localparam int CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load CYCLES-1, then count down to zero while enabled; zero means dwell elapsed
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(CYCLES - 1);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);
endmodule

// File: rtl/pair_checker.sv
// Turn controller for the memory-match board: pick two tiles, compare labels,
// lock matches and score them, or reveal a mismatch then hide it and swap player.
module pair_checker
   import pair_checker_pkg::*;
#(
   parameter int N_TILES     = DEF_N_TILES,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int LABEL_W     = DEF_LABEL_W,
   parameter int SHOW_CYCLES = DEF_SHOW_CYCLES,
   parameter int SCORE_W     = DEF_SCORE_W
) (
   input  logic         clk,
   input  logic         rst,
   pair_checker_if.slave bus
);
   localparam int PAIRS  = N_TILES / 2;
   localparam int PAIR_W = $clog2(PAIRS + 1);

   state_e             state_q,      state_d;
   logic [IDX_W-1:0]   first_idx_q,  first_idx_d;
   logic [IDX_W-1:0]   second_idx_q, second_idx_d;
   logic [N_TILES-1:0] hide_q,       hide_d;
   logic [N_TILES-1:0] matched_q,    matched_d;
   logic               player_q,     player_d;
   logic [SCORE_W-1:0] score0_q,     score0_d;
   logic [SCORE_W-1:0] score1_q,     score1_d;
   logic               busy_q,       busy_d;
   logic               game_over_q,  game_over_d;
   logic [PAIR_W-1:0]  pairs_q,      pairs_d;

   logic cursor_matched;
   logic pick_ok;
   logic labels_equal;
   logic timer_load;
   logic timer_en;
   logic timer_done;

   show_timer #(
      .CYCLES (SHOW_CYCLES)
   ) u_show_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .en   (timer_en),
      .done (timer_done)
   );

   // Pick qualification and label comparison for the latched pair
   always_comb begin
      cursor_matched = 1'b0;
      for (int i = 0; i < N_TILES; i++) begin
         if ((bus.cursor == IDX_W'(i)) && matched_q[i]) begin
            cursor_matched = 1'b1;
         end
      end
      pick_ok = bus.select
             && (32'(bus.cursor) < 32'(N_TILES))
             && !cursor_matched
             && ((state_q == PICK1)
                 || ((state_q == PICK2) && (bus.cursor != first_idx_q)));
      labels_equal = (label_at(FLAT_MAX'(bus.labels), 32'(first_idx_q), 32'(LABEL_W))
                   == label_at(FLAT_MAX'(bus.labels), 32'(second_idx_q), 32'(LABEL_W)));
      timer_load = (state_q == COMPARE) && !labels_equal;
      timer_en   = (state_q == SHOW);
   end

   // Next-state and next-output computation for the turn FSM
   always_comb begin
      state_d      = state_q;
      first_idx_d  = first_idx_q;
      second_idx_d = second_idx_q;
      hide_d       = '0;
      matched_d    = matched_q;
      player_d     = player_q;
      score0_d     = score0_q;
      score1_d     = score1_q;
      pairs_d      = pairs_q;

      case (state_q)
         PICK1: begin
            if (pick_ok) begin
               first_idx_d = bus.cursor;
               state_d     = PICK2;
            end
         end
         PICK2: begin
            if (pick_ok) begin
               second_idx_d = bus.cursor;
               state_d      = COMPARE;
            end
         end
         COMPARE: begin
            if (labels_equal) begin
               for (int i = 0; i < N_TILES; i++) begin
                  if ((first_idx_q == IDX_W'(i)) || (second_idx_q == IDX_W'(i))) begin
                     matched_d[i] = 1'b1;
                  end
               end
               if (!player_q) begin
                  if (score0_q != '1) score0_d = score0_q + SCORE_W'(1);
               end else begin
                  if (score1_q != '1) score1_d = score1_q + SCORE_W'(1);
               end
               pairs_d = pairs_q + PAIR_W'(1);
               state_d = (pairs_d == PAIR_W'(PAIRS)) ? DONE : PICK1;
            end else begin
               state_d = SHOW;
            end
         end
         SHOW: begin
            // hide is raised on entry to HIDE so the pulse lines up with that state
            if (timer_done) begin
               for (int i = 0; i < N_TILES; i++) begin
                  if ((first_idx_q == IDX_W'(i)) || (second_idx_q == IDX_W'(i))) begin
                     hide_d[i] = 1'b1;
                  end
               end
               state_d = HIDE;
            end
         end
         HIDE: begin
            player_d = ~player_q;
            state_d  = PICK1;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = PICK1;
         end
      endcase

      busy_d      = (state_d == COMPARE) || (state_d == SHOW) || (state_d == HIDE);
      game_over_d = game_over_q || (state_d == DONE);
   end

   // All FSM state and outputs registered together; reset aborts any turn in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= PICK1;
         first_idx_q  <= '0;
         second_idx_q <= '0;
         hide_q       <= '0;
         matched_q    <= '0;
         player_q     <= 1'b0;
         score0_q     <= '0;
         score1_q     <= '0;
         busy_q       <= 1'b0;
         game_over_q  <= 1'b0;
         pairs_q      <= '0;
      end else begin
         state_q      <= state_d;
         first_idx_q  <= first_idx_d;
         second_idx_q <= second_idx_d;
         hide_q       <= hide_d;
         matched_q    <= matched_d;
         player_q     <= player_d;
         score0_q     <= score0_d;
         score1_q     <= score1_d;
         busy_q       <= busy_d;
         game_over_q  <= game_over_d;
         pairs_q      <= pairs_d;
      end
   end

   assign bus.hide      = hide_q;
   assign bus.matched   = matched_q;
   assign bus.player    = player_q;
   assign bus.score0    = score0_q;
   assign bus.score1    = score1_q;
   assign bus.busy      = busy_q;
   assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_pair_checker.sv
// Directed bench: 16-tile board for match/mismatch/invalid/reset cases,
// 4-tile board for a complete game.
module tb_pair_checker;
   import pair_checker_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pair_checker_if #(.N_TILES(16), .IDX_W(4), .LABEL_W(4), .SCORE_W(4)) bus_a ();
   pair_checker_if #(.N_TILES(4),  .IDX_W(4), .LABEL_W(4), .SCORE_W(4)) bus_g ();

   pair_checker #(.N_TILES(16), .IDX_W(4), .LABEL_W(4), .SHOW_CYCLES(4), .SCORE_W(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   pair_checker #(.N_TILES(4), .IDX_W(4), .LABEL_W(4), .SHOW_CYCLES(4), .SCORE_W(4)) u_game (
      .clk (clk),
      .rst (rst),
      .bus (bus_g)
   );

   int n_checks = 0;
   int n_errors = 0;
   int hide_cycles = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %-22s got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %-22s value=0x%0h", tag, got);
      end
   endtask

   // Count every cycle in which any hide bit is high on the main board
   always @(negedge clk) begin
      if (bus_a.hide != '0) hide_cycles++;
   end

   task automatic pick_a(input int c);
      @(negedge clk);
      bus_a.select = 1'b1;
      bus_a.cursor = 4'(c);
      @(negedge clk);
      bus_a.select = 1'b0;
   endtask

   task automatic pick_g(input int c);
      @(negedge clk);
      bus_g.select = 1'b1;
      bus_g.cursor = 4'(c);
      @(negedge clk);
      bus_g.select = 1'b0;
   endtask

   initial begin
      int hide_base;
      // main board labels: 0=3 1=3 2=5 3=7 4=9 5=9 6=10 7=11, rest distinct
      bus_a.select = 1'b0;
      bus_a.cursor = '0;
      bus_a.labels = {4'd15, 4'd14, 4'd13, 4'd12, 4'd8, 4'd6, 4'd1, 4'd0,
                      4'd11, 4'd10, 4'd9, 4'd9, 4'd7, 4'd5, 4'd3, 4'd3};
      // game board labels: 1,2,1,2
      bus_g.select = 1'b0;
      bus_g.cursor = '0;
      bus_g.labels = {4'd2, 4'd1, 4'd2, 4'd1};

      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset values
      check("rst_matched",   32'(bus_a.matched),   32'h0);
      check("rst_hide",      32'(bus_a.hide),      32'h0);
      check("rst_player",    32'(bus_a.player),    32'h0);
      check("rst_scores",    {bus_a.score1, bus_a.score0}, 32'h0);
      check("rst_busy",      32'(bus_a.busy),      32'h0);
      check("rst_game_over", 32'(bus_a.game_over), 32'h0);

      // Match: tiles 0 and 1
      pick_a(0);
      check("m_after_pick1_busy", 32'(bus_a.busy), 32'h0);
      pick_a(1);
      check("m_compare_busy",   32'(bus_a.busy),    32'h1);
      check("m_compare_matched",32'(bus_a.matched), 32'h0);
      @(negedge clk);
      check("m_matched",  32'(bus_a.matched), 32'h0003);
      check("m_score0",   32'(bus_a.score0),  32'h1);
      check("m_player",   32'(bus_a.player),  32'h0);
      check("m_busy",     32'(bus_a.busy),    32'h0);
      check("m_no_hide",  32'(hide_cycles),   32'h0);

      // Invalid picks, then mismatch 2 vs 3
      pick_a(2);
      pick_a(2);
      check("inv_same_tile_busy", 32'(bus_a.busy), 32'h0);
      pick_a(0);
      check("inv_matched_busy",   32'(bus_a.busy), 32'h0);
      pick_a(3);
      check("mm_compare_busy",    32'(bus_a.busy), 32'h1);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus_a.select = 1'b1;
            bus_a.cursor = 4'd6;
         end else begin
            bus_a.select = 1'b0;
         end
         if (n == 2) check("mm_show_busy", 32'(bus_a.busy), 32'h1);
         check($sformatf("mm_hide_clk%0d", n + 1), 32'(bus_a.hide), (n == 5) ? 32'h000C : 32'h0);
      end
      check("mm_player",   32'(bus_a.player), 32'h1);
      check("mm_busy",     32'(bus_a.busy),   32'h0);
      check("mm_scores",   {bus_a.score1, bus_a.score0}, 32'h01);
      check("mm_hide_cnt", 32'(hide_cycles),  32'h1);

      // Alternation: player 1 matches 4 and 5 (select during SHOW must not have latched tile 6)
      pick_a(4);
      pick_a(5);
      @(negedge clk);
      check("alt_matched", 32'(bus_a.matched), 32'h0033);
      check("alt_score1",  32'(bus_a.score1),  32'h1);
      check("alt_score0",  32'(bus_a.score0),  32'h1);
      check("alt_player",  32'(bus_a.player),  32'h1);

      // Reset mid-SHOW
      pick_a(6);
      pick_a(7);
      repeat (2) @(negedge clk);
      check("rs_show_busy", 32'(bus_a.busy), 32'h1);
      hide_base = hide_cycles;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rs_matched", 32'(bus_a.matched), 32'h0);
      check("rs_player",  32'(bus_a.player),  32'h0);
      check("rs_scores",  {bus_a.score1, bus_a.score0}, 32'h0);
      check("rs_busy",    32'(bus_a.busy),    32'h0);
      repeat (6) @(negedge clk);
      check("rs_no_hide", 32'(hide_cycles - hide_base), 32'h0);
      pick_a(0);
      pick_a(1);
      @(negedge clk);
      check("rs_first_ok_matched", 32'(bus_a.matched), 32'h0003);
      check("rs_first_ok_score0",  32'(bus_a.score0),  32'h1);

      // Full game on the 4-tile board
      pick_g(5);
      pick_g(0);
      check("g_range_busy", 32'(bus_g.busy), 32'h0);
      pick_g(2);
      check("g_compare_busy", 32'(bus_g.busy), 32'h1);
      @(negedge clk);
      check("g_matched1",  32'(bus_g.matched),   32'h5);
      check("g_score0_1",  32'(bus_g.score0),    32'h1);
      check("g_not_over",  32'(bus_g.game_over), 32'h0);
      pick_g(1);
      pick_g(3);
      @(negedge clk);
      check("g_matched2",  32'(bus_g.matched),   32'hF);
      check("g_score0_2",  32'(bus_g.score0),    32'h2);
      check("g_over",      32'(bus_g.game_over), 32'h1);
      check("g_over_busy", 32'(bus_g.busy),      32'h0);
      pick_g(0);
      pick_g(1);
      check("g_done_busy",  32'(bus_g.busy),   32'h0);
      @(negedge clk);
      check("g_done_score", {bus_g.score1, bus_g.score0}, 32'h02);
      check("g_done_over",  32'(bus_g.game_over), 32'h1);
      check("g_no_hide",    32'(bus_g.hide),      32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
